// File: rtl/mdu_ctrl.sv
// -----------------------------------------------------------------------------
// mdu_ctrl -- multiply/divide unit controller with architectural HI/LO.
//
// An accepted MULT/MULTU/DIV/DIVU computes its result at the accept edge and
// holds it in pend_hi/pend_lo. The unit then stays busy for a fixed latency and
// commits the result to HI/LO on the last busy edge. MTHI/MTLO write HI/LO
// directly at the accept edge and never enter BUSY.
//
// Parameters
//   MULT_CYCLES  busy cycles for MULT/MULTU (1..15)
//   DIV_CYCLES   busy cycles for DIV/DIVU   (1..15)
//
// Ports
//   clk      sole clock, rising edge
//   reset    asynchronous active-low reset
//   start    E-stage MDU instruction valid
//   op       0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 NONE
//   cancel   flush of the E-stage instruction; suppresses the start only
//   rs_val   forwarded rs operand
//   rt_val   forwarded rt operand
//   busy     high while a multiply/divide is in flight
//   hi_out   architectural HI
//   lo_out   architectural LO
// -----------------------------------------------------------------------------
module mdu_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic        cancel,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   output logic        busy,
   output logic [31:0] hi_out,
   output logic [31:0] lo_out
);

   typedef enum logic [2:0] {
      OP_NONE  = 3'd0,
      OP_MULT  = 3'd1,
      OP_MULTU = 3'd2,
      OP_DIV   = 3'd3,
      OP_DIVU  = 3'd4,
      OP_MTHI  = 3'd5,
      OP_MTLO  = 3'd6,
      OP_RSVD  = 3'd7
   } op_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_e;

   state_e      state, state_next;
   logic [3:0]  cnt, cnt_next;
   logic [31:0] pend_hi, pend_lo;
   logic        pend_wr;     // cleared for divide-by-zero so HI/LO stay put
   op_e         op_dec;
   logic        accept, accept_md, done;

   assign op_dec = op_e'(op);

   // ---------------------------------------------------------------- datapath
   // Signed product: the low 64 bits of the product of sign-extended operands.
   logic [63:0] prod_s, prod_u;
   assign prod_s = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
   assign prod_u = {32'd0, rs_val} * {32'd0, rt_val};

   // One unsigned divider serves both divides; signed divide runs on magnitudes
   // and fixes the signs afterwards, which also gives 0x80000000 / -1 the
   // wrapped quotient 0x80000000 with remainder 0.
   logic        is_sdiv, div_zero, neg_q;
   logic [31:0] abs_a, abs_b, div_a, div_b, quo, rem, quo_s, rem_s;

   assign is_sdiv  = (op_dec == OP_DIV);
   assign div_zero = (rt_val == 32'd0);
   assign abs_a    = rs_val[31] ? (~rs_val + 32'd1) : rs_val;
   assign abs_b    = rt_val[31] ? (~rt_val + 32'd1) : rt_val;
   assign div_a    = is_sdiv ? abs_a : rs_val;
   assign div_b    = div_zero ? 32'd1 : (is_sdiv ? abs_b : rt_val);
   assign quo      = div_a / div_b;
   assign rem      = div_a % div_b;
   assign neg_q    = rs_val[31] ^ rt_val[31];
   assign quo_s    = neg_q      ? (~quo + 32'd1) : quo;
   assign rem_s    = rs_val[31] ? (~rem + 32'd1) : rem;

   logic [31:0] res_hi, res_lo;
   logic        res_wr;

   // NOTE: every signal written here gets a default first, so no path through
   // the case can leave it unassigned and infer a latch.
   always_comb begin
      res_hi = 32'd0;
      res_lo = 32'd0;
      res_wr = 1'b0;
      case (op_dec)
         OP_MULT:  begin res_hi = prod_s[63:32]; res_lo = prod_s[31:0]; res_wr = 1'b1; end
         OP_MULTU: begin res_hi = prod_u[63:32]; res_lo = prod_u[31:0]; res_wr = 1'b1; end
         OP_DIV:   begin res_hi = rem_s;         res_lo = quo_s;        res_wr = ~div_zero; end
         OP_DIVU:  begin res_hi = rem;           res_lo = quo;          res_wr = ~div_zero; end
         default:  ;
      endcase
   end

   // ---------------------------------------------------------------- control
   // Starts in BUSY, under cancel, or with op 0/7 are dropped without effect.
   assign accept    = start && !cancel && (state == ST_IDLE) &&
                      (op_dec != OP_NONE) && (op_dec != OP_RSVD);
   assign accept_md = accept && (op_dec inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU});

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      done       = 1'b0;
      case (state)
         ST_IDLE: begin
            if (accept_md) begin
               state_next = ST_BUSY;
               cnt_next   = (op_dec inside {OP_MULT, OP_MULTU}) ? 4'(MULT_CYCLES - 1)
                                                               : 4'(DIV_CYCLES - 1);
            end
         end
         ST_BUSY: begin
            // cancel is deliberately ignored here: an issued op always commits.
            if (cnt == 4'd0) begin
               state_next = ST_IDLE;
               done       = 1'b1;
            end else begin
               cnt_next = cnt - 4'd1;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
         cnt   <= 4'd0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pend_hi <= 32'd0;
         pend_lo <= 32'd0;
         pend_wr <= 1'b0;
         hi_out  <= 32'd0;
         lo_out  <= 32'd0;
      end else begin
         if (accept_md) begin
            pend_hi <= res_hi;
            pend_lo <= res_lo;
            pend_wr <= res_wr;
         end
         // done and accept are exclusive: accept needs IDLE, done needs BUSY.
         if (done && pend_wr) begin
            hi_out <= pend_hi;
            lo_out <= pend_lo;
         end
         if (accept && (op_dec == OP_MTHI)) hi_out <= rs_val;
         if (accept && (op_dec == OP_MTLO)) lo_out <= rs_val;
      end
   end

   assign busy = (state == ST_BUSY);

endmodule

// File: tb/tb_mdu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mdu_ctrl -- self-checking bench for mdu_ctrl.
// Directed scenarios for the documented corner cases followed by randomized
// traffic, all compared every cycle against a behavioural model that tracks
// remaining busy cycles and computes results with 64-bit integer arithmetic.
// -----------------------------------------------------------------------------
module tb_mdu_ctrl;

   localparam int MC = 5;
   localparam int DC = 10;

   logic        clk;
   logic        reset;
   logic        start;
   logic [2:0]  op;
   logic        cancel;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic        busy;
   logic [31:0] hi_out;
   logic [31:0] lo_out;

   mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .op     (op),
      .cancel (cancel),
      .rs_val (rs_val),
      .rt_val (rt_val),
      .busy   (busy),
      .hi_out (hi_out),
      .lo_out (lo_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // ------------------------------------------------------------- reference
   int          m_left;          // busy cycles still to run
   logic [31:0] m_hi, m_lo, m_phi, m_plo;
   logic        m_pvalid;

   task automatic model_clear();
      m_left = 0; m_hi = '0; m_lo = '0; m_phi = '0; m_plo = '0; m_pvalid = 1'b0;
   endtask

   task automatic ref_result(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                             output logic [31:0] h, output logic [31:0] l, output logic v);
      longint      sa, sb, q, r;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      h = '0; l = '0; v = 1'b1;
      case (o)
         3'd1: begin q = sa * sb; p = 64'(q); h = p[63:32]; l = p[31:0]; end
         3'd2: begin p = 64'(a) * 64'(b); h = p[63:32]; l = p[31:0]; end
         3'd3: if (b == 0) v = 1'b0;
               else begin q = sa / sb; r = sa % sb; l = 32'(q); h = 32'(r); end
         default: if (b == 0) v = 1'b0;
                  else begin l = a / b; h = a % b; end
      endcase
   endtask

   // One clock: drive inputs, let the edge happen, advance the model, compare.
   task automatic tick(input logic s, input logic [2:0] o, input logic c,
                       input logic [31:0] a, input logic [31:0] b);
      logic [31:0] rh, rl;
      logic        rv;
      start = s; op = o; cancel = c; rs_val = a; rt_val = b;
      @(posedge clk);
      #1;
      if (m_left > 0) begin
         m_left--;
         if (m_left == 0 && m_pvalid) begin m_hi = m_phi; m_lo = m_plo; end
      end else if (s && !c) begin
         case (o)
            3'd1, 3'd2, 3'd3, 3'd4: begin
               ref_result(o, a, b, rh, rl, rv);
               m_phi = rh; m_plo = rl; m_pvalid = rv;
               m_left = (o <= 3'd2) ? MC : DC;
            end
            3'd5: m_hi = a;
            3'd6: m_lo = a;
            default: ;
         endcase
      end
      check("busy", {31'd0, busy}, {31'd0, m_left != 0});
      check("hi",   hi_out, m_hi);
      check("lo",   lo_out, m_lo);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b0, 3'd0, 1'b0, $urandom, $urandom);
   endtask

   // Asynchronous reset mid-cycle; outputs must clear before any clock edge.
   task automatic do_reset();
      #2;
      reset = 1'b0;
      #1;
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_hi",   hi_out, 32'd0);
      check("rst_lo",   lo_out, 32'd0);
      model_clear();
      #3;
      reset = 1'b1;
   endtask

   function automatic logic [31:0] pick_operand();
      logic [31:0] edges [6];
      edges = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'hFFFF_FFFE};
      if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 5)];
      return $urandom;
   endfunction

   initial begin
      model_clear();
      reset = 1'b0; start = 1'b0; op = 3'd0; cancel = 1'b0; rs_val = '0; rt_val = '0;
      #12;
      check("init_busy", {31'd0, busy}, 32'd0);
      check("init_hi",   hi_out, 32'd0);
      check("init_lo",   lo_out, 32'd0);
      reset = 1'b1;

      // MULT -2 * 3, accepted on the first edge after reset release
      tick(1'b1, 3'd1, 1'b0, 32'hFFFF_FFFE, 32'h3);
      check("mult_busy_on", {31'd0, busy}, 32'd1);
      idle(MC);
      check("mult_hi", hi_out, 32'hFFFF_FFFF);
      check("mult_lo", lo_out, 32'hFFFF_FFFA);
      check("mult_busy_off", {31'd0, busy}, 32'd0);

      // DIVU 7/2 and DIV -7/2
      tick(1'b1, 3'd4, 1'b0, 32'd7, 32'd2);
      idle(DC);
      check("divu_lo", lo_out, 32'd3);
      check("divu_hi", hi_out, 32'd1);
      tick(1'b1, 3'd3, 1'b0, 32'hFFFF_FFF9, 32'd2);
      idle(DC);
      check("div_lo", lo_out, 32'hFFFF_FFFD);
      check("div_hi", hi_out, 32'hFFFF_FFFF);

      // MTHI in IDLE
      tick(1'b1, 3'd5, 1'b0, 32'h1234_5678, 32'h0);
      check("mthi_hi", hi_out, 32'h1234_5678);
      check("mthi_busy", {31'd0, busy}, 32'd0);

      // Starts during BUSY are ignored
      tick(1'b1, 3'd1, 1'b0, 32'd3, 32'd4);
      tick(1'b1, 3'd6, 1'b0, 32'hDEAD_BEEF, 32'h0);
      tick(1'b1, 3'd1, 1'b0, 32'd100, 32'd100);
      idle(MC - 2);
      check("ign_lo", lo_out, 32'd12);
      check("ign_hi", hi_out, 32'd0);

      // Cancelled start, then cancel pulsed during BUSY
      tick(1'b1, 3'd1, 1'b1, 32'd5, 32'd5);
      check("cancel_busy", {31'd0, busy}, 32'd0);
      tick(1'b1, 3'd1, 1'b0, 32'd2, 32'd3);
      tick(1'b0, 3'd0, 1'b1, 32'd0, 32'd0);
      idle(MC - 1);
      check("cancel_inflight_lo", lo_out, 32'd6);

      // Divide by zero keeps HI/LO
      tick(1'b1, 3'd3, 1'b0, 32'd9, 32'd0);
      idle(DC);
      check("dz_lo", lo_out, 32'd6);
      check("dz_hi", hi_out, 32'd0);

      // Reset on busy cycle 3 of a DIV discards the result
      tick(1'b1, 3'd3, 1'b0, 32'd100, 32'd7);
      idle(2);
      do_reset();
      idle(DC + 2);
      check("rst_nocommit_lo", lo_out, 32'd0);

      // Overflow divide, then MULTU issued the cycle after busy falls
      tick(1'b1, 3'd3, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
      idle(DC);
      check("ovf_lo", lo_out, 32'h8000_0000);
      check("ovf_hi", hi_out, 32'h0);
      tick(1'b1, 3'd2, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      check("b2b_busy", {31'd0, busy}, 32'd1);
      idle(MC);
      check("multu_hi", hi_out, 32'hFFFF_FFFE);
      check("multu_lo", lo_out, 32'h0000_0001);

      // Randomized traffic
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(0, 199) == 0) do_reset();
         tick($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
              $urandom_range(0, 7) == 0, pick_operand(), pick_operand());
      end
      idle(DC + 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 Parameter MULT_CYCLES, default 5: busy cycles for MULT/MULTU, legal range 1..15.
REQ-002 Parameter DIV_CYCLES, default 10: busy cycles for DIV/DIVU, legal range 1..15.
REQ-003 clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  E-stage MDU instruction valid this cycle.
REQ-006 op  input  3  0=NONE, 1=MULT, 2=MULTU, 3=DIV, 4=DIVU, 5=MTHI, 6=MTLO; 7 is treated as NONE.
REQ-007 cancel  input  1  exception/flush on the E-stage instruction; suppresses the start.
REQ-008 rs_val  input  32  forwarded rs operand.
REQ-009 rt_val  input  32  forwarded rt operand.
REQ-010 busy  output  1  registered; high while a multiply/divide is in flight.
REQ-011 hi_out  output  32  architectural HI register.
REQ-012 lo_out  output  32  architectural LO register.

Function
REQ-013 The states SHALL be IDLE and BUSY, plus a 4-bit down-counter cnt.
REQ-014 Accept SHALL mean: start=1, cancel=0, state=IDLE and op in 1..6.
- Any other start is ignored, with no state change.
- This includes a start in BUSY, any op while cancel=1, and op 0 or 7.
REQ-015 An accepted op in 1..4 SHALL latch its result into internal pend_hi/pend_lo at the accept edge.
- State goes to BUSY.
- cnt loads MULT_CYCLES-1 (MULT/MULTU) or DIV_CYCLES-1 (DIV/DIVU).
REQ-016 In BUSY, cnt SHALL decrement each edge.
- At the edge where cnt=0: hi_out<=pend_hi, lo_out<=pend_lo, state goes to IDLE.
REQ-017 busy SHALL be 1 exactly when state=BUSY.
- Busy therefore lasts exactly N cycles after the accept edge, where N = MULT_CYCLES or DIV_CYCLES.
REQ-018 The hazard unit stalls MFHI/MFLO/MTHI/MTLO/MDU ops on (start & op in 1..4) | busy.
- This block SHALL NOT generate a stall itself.
REQ-019 MULT SHALL compute the signed 64-bit product of rs_val and rt_val: HI = [63:32], LO = [31:0].
REQ-020 MULTU SHALL compute the same as MULT with unsigned operands.
REQ-021 DIV SHALL set LO to the signed quotient truncated toward zero and HI to the remainder carrying the dividend's sign.
REQ-022 DIVU SHALL be unsigned: LO = quotient, HI = remainder.
REQ-023 Signed divide of 0x80000000 by 0xFFFFFFFF SHALL yield LO=0x80000000, HI=0x00000000.
REQ-024 Divide by zero (rt_val=0, DIV or DIVU) SHALL still occupy DIV_CYCLES busy cycles, and HI/LO SHALL be left unchanged at completion.
REQ-025 An accepted MTHI SHALL set hi_out<=rs_val at the accept edge, with no BUSY state and no effect on lo_out.
REQ-026 An accepted MTLO SHALL behave as MTHI, with lo_out and hi_out swapped.
REQ-027 cancel asserted while in BUSY SHALL NOT abort the operation in flight.
- An instruction already issued commits, per the precise-exception convention.
REQ-028 A new accept SHALL be possible in the cycle immediately after busy falls.
- Back-to-back throughput is one op per N+1 cycles.
REQ-029 hi_out and lo_out SHALL change only at a completion edge (REQ-016) or an MTHI/MTLO accept edge (REQ-025, REQ-026).

Reset
REQ-030 reset=0 SHALL immediately force state=IDLE, cnt=0, busy=0, hi_out=0, lo_out=0, pend_hi=0, pend_lo=0, independent of clk.
REQ-031 Reset asserted mid-operation SHALL discard the pending result.
- After release, no commit occurs.
REQ-032 The first accept SHALL be possible on the first rising edge after reset returns high.

Verification
REQ-033 MULT, rs=0xFFFFFFFE (-2), rt=0x00000003 -> busy high for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA; busy=0 on the same edge.
REQ-034 DIVU, rs=0x00000007, rt=0x00000002 -> 10 busy cycles; then LO=0x00000003, HI=0x00000001. DIV, rs=0xFFFFFFF9 (-7), rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-035 MTHI rs=0x12345678 in IDLE -> hi_out=0x12345678 next edge, busy stays 0. A MTLO or MULT start during BUSY -> ignored; HI/LO take only the first op's result.
REQ-036 MULT with start=1, cancel=1 -> busy stays 0, HI/LO unchanged. cancel pulsed during BUSY -> result still commits on schedule.
REQ-037 DIV by zero, or reset dropped on busy cycle 3 of a DIV -> the first keeps HI/LO unchanged after 10 cycles; the second reads all outputs 0 immediately, with no later commit.
REQ-038 DIV 0x80000000 / 0xFFFFFFFF, then MULTU 0xFFFFFFFF*0xFFFFFFFF issued the cycle after busy falls -> LO=0x80000000, HI=0; then HI=0xFFFFFFFE, LO=0x00000001.
